// File: rtl/bsg_mcl_word_assembler.sv
// bsg_mcl_word_assembler: packs els_p AXIL words into one manycore packet; stats counters enabled by BSG_MCL_WORD_ASSEMBLER_STATS_EN
module bsg_mcl_word_assembler #(
  parameter int word_width_p = 32,
  parameter int els_p = 4,
  parameter int cnt_width_p = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic [word_width_p-1:0]         data_i,
  output logic                            ready_o,
  input  logic                            flush_i,
  output logic                            v_o,
  output logic [word_width_p*els_p-1:0]   data_o,
  input  logic                            ready_i,
  output logic [$clog2(els_p+1)-1:0]      word_cnt_o,
  output logic [cnt_width_p-1:0]          pkt_cnt_o,
  output logic [cnt_width_p-1:0]          drop_cnt_o
);
  localparam int wc_width_lp = $clog2(els_p+1);
  localparam int idx_width_lp = $clog2(els_p);
  typedef enum logic {FILL, HOLD} state_e;
  state_e state_q, state_d;
  logic [wc_width_lp-1:0] word_cnt_q, word_cnt_d;
  logic [els_p-1:0][word_width_p-1:0] asm_q, pkt_w, out_q;
  logic out_v_q, out_v_d;
  logic accept, last, out_free, load, drop;
  assign accept = v_i & ready_o;
  assign last = accept & (word_cnt_q == wc_width_lp'(els_p-1));
  assign out_free = ~out_v_q | ready_i;
  assign load = (last & out_free) | ((state_q == HOLD) & ready_i);
  assign drop = flush_i & (state_q == FILL) & (word_cnt_q != '0);
  assign v_o = out_v_q;
  assign data_o = out_q;
  assign word_cnt_o = word_cnt_q;
  // control state: fill/hold state, word count and output-valid flag
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= FILL;
      word_cnt_q <= '0;
      out_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_cnt_q <= word_cnt_d;
      out_v_q <= out_v_d;
    end
  // next state: a completed packet either goes straight out or waits in HOLD
  always_comb begin
    state_d = state_q;
    word_cnt_d = word_cnt_q;
    if (state_q == HOLD) begin
      state_d = ready_i ? FILL : HOLD;
      word_cnt_d = ready_i ? '0 : word_cnt_q;
    end else if (drop)
      word_cnt_d = '0;
    else if (last) begin
      state_d = out_free ? FILL : HOLD;
      word_cnt_d = out_free ? '0 : wc_width_lp'(els_p);
    end else if (accept)
      word_cnt_d = word_cnt_q + wc_width_lp'(1);
  end
  // outputs: handshake toward upstream and output-register occupancy
  always_comb begin
    ready_o = ~reset_i & (state_q == FILL) & ~flush_i;
    out_v_d = load | (out_v_q & ~ready_i);
  end
  // packet image: in FILL the final word comes straight from data_i
  always_comb begin
    pkt_w = asm_q;
    if (state_q == FILL) pkt_w[els_p-1] = data_i;
  end
  // data registers carry no reset; validity lives in the control state
  always_ff @(posedge clk_i) begin
    if (accept) asm_q[word_cnt_q[idx_width_lp-1:0]] <= data_i;
    if (load) out_q <= pkt_w;
  end
`ifdef BSG_MCL_WORD_ASSEMBLER_STATS_EN
  logic [cnt_width_p-1:0] pkt_cnt_q, drop_cnt_q;
  // saturating counters of delivered packets and flushed partials
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      pkt_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (out_v_q & ready_i & ~&pkt_cnt_q) pkt_cnt_q <= pkt_cnt_q + cnt_width_p'(1);
      if (drop & ~&drop_cnt_q) drop_cnt_q <= drop_cnt_q + cnt_width_p'(1);
    end
  assign pkt_cnt_o = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  assign pkt_cnt_o = '0;
  assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bsg_mcl_word_assembler.sv
// tb_bsg_mcl_word_assembler: vector table plus packet scoreboard for the word assembler
module tb_bsg_mcl_word_assembler;
  localparam int W = 32, E = 4, C = 32, CW = $clog2(E+1);
`ifdef BSG_MCL_WORD_ASSEMBLER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk_i = 1'b0, reset_i = 1'b0, v_i = 1'b0, flush_i = 1'b0, ready_i = 1'b1;
  logic [W-1:0] data_i = '0;
  logic ready_o, v_o;
  logic [W*E-1:0] data_o;
  logic [CW-1:0] word_cnt_o;
  logic [C-1:0] pkt_cnt_o, drop_cnt_o;
  int tests = 0, fails = 0, cyc = 0;
  logic [W*E-1:0] exp_q[$];
  logic [W-1:0] asm_m[$];
  int xfer_cyc[$];
  typedef struct {logic v; logic [W-1:0] d; logic f; logic r; logic rdy; int wcnt; logic vo; int pc; int dc;} vec_t;
  vec_t vecs[16];

  bsg_mcl_word_assembler #(.word_width_p(W), .els_p(E), .cnt_width_p(C)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .flush_i(flush_i), .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
    .word_cnt_o(word_cnt_o), .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [C-1:0] ce(input int n);
    return STATS ? C'(n) : '0;
  endfunction

  // scoreboard: model packets from accepted words, compare on each transfer
  always @(negedge clk_i) begin
    logic [W*E-1:0] p;
    #3;
    if (!reset_i) begin
      if (v_o && ready_i) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pkt_unexpected: got %0h with no packet expected", data_o);
        end else chk("pkt_data", data_o, exp_q.pop_front());
      end
      if (v_i && ready_o) begin
        asm_m.push_back(data_i);
        if (asm_m.size() == E) begin
          for (int i = 0; i < E; i++) p[i*W +: W] = asm_m[i];
          exp_q.push_back(p);
          asm_m.delete();
        end
      end else if (flush_i) asm_m.delete();
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    @(negedge clk_i);
    v_i = v;
    data_i = d;
    flush_i = f;
    ready_i = r;
    #1;
  endtask

  task automatic fill_hold(input logic [W-1:0] base, output int acc);
    acc = 0;
    for (int k = 0; k < 20 && acc < 8; k++) begin
      step(1'b1, base + W'(acc), 1'b0, 1'b0);
      if (ready_o) acc++;
    end
  endtask

  task automatic mid_reset(input string tag);
    #1;
    reset_i = 1'b1;
    exp_q.delete();
    asm_m.delete();
    #1;
    chk({tag, "_vo"}, v_o, 0);
    chk({tag, "_wcnt"}, word_cnt_o, 0);
    chk({tag, "_ready"}, ready_o, 0);
    chk({tag, "_pkt"}, pkt_cnt_o, 0);
    chk({tag, "_drop"}, drop_cnt_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    int acc;
    logic ok;
    vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 0};
    vecs[2]  = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 2, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 3, 1'b0, 0, 0};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 0, 1'b1, 0, 0};
    vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 0};
    vecs[6]  = '{1'b1, 32'ha1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 0};
    vecs[7]  = '{1'b1, 32'ha2, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1, 0};
    vecs[8]  = '{1'b1, 32'ha3, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1, 0};
    vecs[9]  = '{1'b1, 32'hb1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 1};
    vecs[10] = '{1'b1, 32'hb2, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1, 1};
    vecs[11] = '{1'b1, 32'hb3, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1, 1};
    vecs[12] = '{1'b1, 32'hb4, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1, 1};
    vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 0, 1'b1, 1, 1};
    vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 0, 1'b0, 2, 1};
    vecs[15] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 0, 1'b0, 2, 1};
    reset_i = 1'b1;
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_vo", v_o, 0);
    chk("rst_wcnt", word_cnt_o, 0);
    chk("rst_pkt", pkt_cnt_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].r);
      chk($sformatf("vec%0d_ready", i), ready_o, vecs[i].rdy);
      chk($sformatf("vec%0d_wcnt", i), word_cnt_o, vecs[i].wcnt);
      chk($sformatf("vec%0d_vo", i), v_o, vecs[i].vo);
      chk($sformatf("vec%0d_pkt", i), pkt_cnt_o, ce(vecs[i].pc));
      chk($sformatf("vec%0d_drop", i), drop_cnt_o, ce(vecs[i].dc));
    end
    xfer_cyc.delete();
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 32'h100 + W'(k), 1'b0, 1'b1);
      if (ready_o !== 1'b1) ok = 1'b0;
    end
    chk("b2b_ready", ok, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("b2b_npkt", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      chk("b2b_gap1", xfer_cyc[1] - xfer_cyc[0], 4);
      chk("b2b_gap2", xfer_cyc[2] - xfer_cyc[1], 4);
    end
    fill_hold(32'hc0, acc);
    chk("hold_accepted", acc, 8);
    step(1'b1, 32'hc8, 1'b0, 1'b0);
    chk("hold_ready", ready_o, 0);
    chk("hold_wcnt", word_cnt_o, 4);
    chk("hold_vo", v_o, 1);
    step(1'b1, 32'hc8, 1'b1, 1'b0);
    chk("hold_flush_ignored", word_cnt_o, 4);
    xfer_cyc.delete();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("hold_exit_wcnt", word_cnt_o, 0);
    chk("hold_exit_ready", ready_o, 1);
    chk("hold_npkt", xfer_cyc.size(), 2);
    if (xfer_cyc.size() == 2) chk("hold_consecutive", xfer_cyc[1] - xfer_cyc[0], 1);
    for (int k = 0; k < 3; k++) step(1'b1, 32'hd0 + W'(k), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("mid_pkt_wcnt", word_cnt_o, 3);
    mid_reset("rst_fill");
    fill_hold(32'he0, acc);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("mid_hold_wcnt", word_cnt_o, 4);
    chk("mid_hold_vo", v_o, 1);
    mid_reset("rst_hold");
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b1);
    chk("post_rst_vo", v_o, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bsg_mcl_word_assembler.md
BSG_MCL_WORD_ASSEMBLER -- requirements
Module: bsg_mcl_word_assembler

Interface
REQ-001 SHALL have parameter word_width_p, default 32: width of one AXIL FIFO word.
REQ-002 SHALL have parameter els_p, default 4: words per manycore FIFO packet; legal range 2..16.
REQ-003 SHALL have parameter cnt_width_p, default 32: width of the statistics counters.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port v_i, input, 1 bit: upstream word valid.
REQ-007 SHALL have port data_i, input, word_width_p bits: upstream word.
REQ-008 SHALL have port ready_o, output, 1 bit: word accepted when v_i & ready_o.
REQ-009 SHALL have port flush_i, input, 1 bit: discard the partially assembled packet.
REQ-010 SHALL have port v_o, output, 1 bit: packet valid toward the endpoint FIFO.
REQ-011 SHALL have port data_o, output, word_width_p*els_p bits: assembled packet.
REQ-012 SHALL have port ready_i, input, 1 bit: packet consumed when v_o & ready_i.
REQ-013 SHALL have port word_cnt_o, output, $clog2(els_p+1) bits: words held in the assembly register.
REQ-014 SHALL have port pkt_cnt_o, output, cnt_width_p bits: packets delivered.
REQ-015 SHALL have port drop_cnt_o, output, cnt_width_p bits: partial packets flushed.

Function
REQ-016 SHALL hold an assembly register of els_p words and one output packet register (out_v).
REQ-017 SHALL implement states FILL (word_cnt < els_p) and HOLD (word_cnt == els_p, out_v=1, packet not yet transferred).
REQ-018 SHALL drive ready_o = (state==FILL) & ~flush_i.
REQ-019 SHALL write an accepted word into slot word_cnt, with slot 0 at data_o[word_width_p-1:0], and increment word_cnt.
REQ-020 SHALL, on accepting the word for slot els_p-1, move the packet to the output register next cycle if out_v==0 or ready_i==1 that cycle, and reset word_cnt to 0.
REQ-021 SHALL otherwise enter HOLD with word_cnt=els_p, and transfer to the output register on the first cycle with ready_i=1 (the old packet dequeues and the new one loads in the same edge), then return to FILL.
REQ-022 SHALL assert v_o exactly one cycle after the final word is accepted, when the output register is free.
REQ-023 SHALL sustain one word per cycle with ready_i held 1; no bubble between packets.
REQ-024 SHALL keep data_o stable while v_o=1 and ready_i=0.
REQ-025 SHALL, on flush_i in FILL with word_cnt>0, clear word_cnt to 0 and increment drop_cnt_o; flush with word_cnt==0 SHALL have no effect.
REQ-026 SHALL ignore flush_i in HOLD; a completed packet is never dropped.
REQ-027 SHALL never let flush_i affect the output register.
REQ-028 SHALL increment pkt_cnt_o on each v_o & ready_i.
REQ-029 SHALL saturate both counters at all-ones, with no wrap.

Reset
REQ-030 SHALL, on reset_i assertion and independent of clk_i, clear word_cnt, out_v, pkt_cnt_o, drop_cnt_o and the state (to FILL); this forces v_o=0 and ready_o=0 while reset_i=1.
REQ-031 SHALL discard partial and held packets on a mid-operation reset; the data registers need no reset.

Configuration
REQ-032 SHALL, with BSG_MCL_WORD_ASSEMBLER_STATS_EN defined, implement pkt_cnt_o and drop_cnt_o per REQ-025..029.
REQ-033 SHALL, without the macro, keep both ports and tie them to 0 with no counter flops.

Verification
REQ-034 SHALL test this: reset, then words 0x11,0x22,0x33,0x44 on consecutive cycles with ready_i=1 -> v_o one cycle after 0x44 with data_o=0x00000044_00000033_00000022_00000011; pkt_cnt_o=1.
REQ-035 SHALL test this: 12 back-to-back words with ready_i=1 -> 3 packets on v_o at 4-cycle spacing; ready_o stays 1 throughout.
REQ-036 SHALL test this: ready_i=0 while 8 words are offered -> first packet in the output register, second in HOLD, ready_o=0, word_cnt_o=4; raise ready_i -> both packets delivered in order on consecutive cycles.
REQ-037 SHALL test this: 2 words, then flush_i with v_i=1 -> word not accepted, word_cnt_o=0, drop_cnt_o=1; the next 4 words form a clean packet.
REQ-038 SHALL test this: reset_i asserted mid-packet (word_cnt_o=3) and mid-HOLD -> v_o=0, word_cnt_o=0, counters=0 immediately, before the next clock edge.
REQ-039 SHALL test this: the macro undefined -> pkt_cnt_o=drop_cnt_o=0 after the REQ-034 and REQ-037 sequences.
